// File: rtl/reg_file_multiport_sb.sv
// Multi-port register file: N synchronous read ports with two-port write bypass,
// register 0 hardwired to zero, and a busy-bit scoreboard for operand readiness.
module reg_file_multiport_sb #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REGS       = 16,
   parameter int NUM_READ_PORTS = 3,
   localparam int SEL_W         = $clog2(NUM_REGS)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_READ_PORTS*SEL_W-1:0]      rd_sel_i,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_o,
   output logic [NUM_READ_PORTS-1:0]            rd_ready_o,
   input  logic [1:0]                          wr_en_i,
   input  logic [2*SEL_W-1:0]                  wr_sel_i,
   input  logic [2*DATA_WIDTH-1:0]             wr_data_i,
   input  logic                                rsv_en_i,
   input  logic [SEL_W-1:0]                    rsv_sel_i,
   output logic [NUM_REGS-1:0]                 busy_o
);

   logic [DATA_WIDTH-1:0]                 regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]                 regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]                   busy_q, busy_d;
   logic [NUM_REGS-1:0]                   clr;
   logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic [NUM_READ_PORTS-1:0]             rd_ready_q, rd_ready_d;

   logic [1:0]            wr_eff;
   logic [SEL_W-1:0]      wsel0, wsel1;
   logic [DATA_WIDTH-1:0] wdat0, wdat1;

   assign wsel0  = wr_sel_i[0 +: SEL_W];
   assign wsel1  = wr_sel_i[SEL_W +: SEL_W];
   assign wdat0  = wr_data_i[0 +: DATA_WIDTH];
   assign wdat1  = wr_data_i[DATA_WIDTH +: DATA_WIDTH];
   assign wr_eff = {wr_en_i[1] && (wsel1 != '0), wr_en_i[0] && (wsel0 != '0)};

   // Port 1 is applied last so it wins a same-register conflict.
   always_comb begin
      clr    = '0;
      busy_d = busy_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         if (r != 0) begin
            if (wr_eff[0] && (wsel0 == SEL_W'(r))) begin
               regs_d[r] = wdat0;
               clr[r]    = 1'b1;
            end
            if (wr_eff[1] && (wsel1 == SEL_W'(r))) begin
               regs_d[r] = wdat1;
               clr[r]    = 1'b1;
            end
            if (rsv_en_i && (rsv_sel_i == SEL_W'(r))) begin
               busy_d[r] = 1'b1;
            end else if (clr[r]) begin
               busy_d[r] = 1'b0;
            end
         end else begin
            regs_d[r] = '0;
            busy_d[r] = 1'b0;
         end
      end
   end

   // Ready looks at busy after this cycle's clear but before its set.
   always_comb begin
      rd_data_d  = '0;
      rd_ready_d = '1;
      for (int i = 0; i < NUM_READ_PORTS; i++) begin
         logic [SEL_W-1:0] s;
         s = rd_sel_i[i*SEL_W +: SEL_W];
         if (s != '0) begin
            if (wr_eff[1] && (wsel1 == s)) begin
               rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = wdat1;
            end else if (wr_eff[0] && (wsel0 == s)) begin
               rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = wdat0;
            end else begin
               rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[s];
            end
            rd_ready_d[i] = !(busy_q[s] && !clr[s]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         busy_q     <= '0;
         rd_data_q  <= '0;
         rd_ready_q <= '1;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
         busy_q     <= busy_d;
         rd_data_q  <= rd_data_d;
         rd_ready_q <= rd_ready_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_ready_o = rd_ready_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_reg_file_multiport_sb.sv
// Directed bench for reg_file_multiport_sb with hand-computed expectations.
module tb_reg_file_multiport_sb;

   localparam int DW = 32;
   localparam int NR = 16;
   localparam int NP = 3;
   localparam int SW = 4;

   logic              clk;
   logic              rst;
   logic [NP*SW-1:0]  rd_sel;
   logic [NP*DW-1:0]  rd_data;
   logic [NP-1:0]     rd_ready;
   logic [1:0]        wr_en;
   logic [2*SW-1:0]   wr_sel;
   logic [2*DW-1:0]   wr_data;
   logic              rsv_en;
   logic [SW-1:0]     rsv_sel;
   logic [NR-1:0]     busy;

   int checks   = 0;
   int failures = 0;

   reg_file_multiport_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ_PORTS(NP)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rd_sel_i   (rd_sel),
      .rd_data_o  (rd_data),
      .rd_ready_o (rd_ready),
      .wr_en_i    (wr_en),
      .wr_sel_i   (wr_sel),
      .wr_data_i  (wr_data),
      .rsv_en_i   (rsv_en),
      .rsv_sel_i  (rsv_sel),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      wr_en  = 2'b00;
      wr_sel = '0;
      wr_data = '0;
      rsv_en = 1'b0;
      rsv_sel = '0;
   endtask

   task automatic wr(input int p, input logic [SW-1:0] s, input logic [DW-1:0] d);
      wr_en[p]            = 1'b1;
      wr_sel[p*SW +: SW]  = s;
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic rsel(input int i, input logic [SW-1:0] s);
      rd_sel[i*SW +: SW] = s;
   endtask

   function automatic logic [DW-1:0] rdat(input int i);
      return rd_data[i*DW +: DW];
   endfunction

   initial begin
      rst = 1'b1;
      rd_sel = '0;
      quiet();
      tick();
      tick();
      check("rst_rd0", rdat(0), 0);
      check("rst_rd1", rdat(1), 0);
      check("rst_rd2", rdat(2), 0);
      check("rst_ready", rd_ready, 3'b111);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      // Basic write then read
      wr(0, 4'd5, 32'hDEADBEEF);
      tick();
      quiet();
      rsel(0, 4'd5);
      rsel(1, 4'd0);
      tick();
      check("basic_rd0", rdat(0), 32'hDEADBEEF);
      check("basic_ready0", rd_ready[0], 1'b1);
      check("basic_rd1_zero", rdat(1), 0);

      // Same-cycle bypass from port 0
      wr(0, 4'd3, 32'h1234);
      rsel(2, 4'd3);
      tick();
      check("bypass_p0", rdat(2), 32'h1234);
      quiet();
      tick();
      check("stored_r3", rdat(2), 32'h1234);

      // Write conflict: port 1 wins; write to reg 0 ignored
      wr(0, 4'd7, 32'hAAAA);
      wr(1, 4'd7, 32'hBBBB);
      rsel(0, 4'd7);
      tick();
      check("conflict_bypass", rdat(0), 32'hBBBB);
      quiet();
      tick();
      check("conflict_stored", rdat(0), 32'hBBBB);
      wr(0, 4'd0, 32'hFFFF);
      rsel(1, 4'd0);
      tick();
      check("wr_r0_bypass", rdat(1), 0);
      quiet();
      tick();
      check("wr_r0_stored", rdat(1), 0);
      check("wr_r0_busy", busy, 0);

      // Port 1 alone, bypass and stored
      wr(1, 4'd8, 32'h77);
      rsel(1, 4'd8);
      tick();
      check("bypass_p1", rdat(1), 32'h77);
      quiet();
      tick();
      check("stored_r8", rdat(1), 32'h77);
      check("r3_unchanged", rdat(2), 32'h1234);

      // Scoreboard reserve / pending read / clearing write
      rsv_en = 1'b1;
      rsv_sel = 4'd4;
      tick();
      check("rsv4_busy", busy, 16'h0010);
      quiet();
      rsel(0, 4'd4);
      tick();
      check("rsv4_not_ready", rd_ready[0], 1'b0);
      check("rsv4_other_ready", rd_ready[2], 1'b1);
      wr(0, 4'd4, 32'h55);
      tick();
      check("clr4_data", rdat(0), 32'h55);
      check("clr4_ready", rd_ready[0], 1'b1);
      check("clr4_busy", busy, 0);
      quiet();

      // Self-reserve, set-wins, rsv to reg 0 ignored
      rsv_en = 1'b1;
      rsv_sel = 4'd9;
      rsel(1, 4'd9);
      tick();
      check("self_rsv_ready", rd_ready[1], 1'b1);
      check("self_rsv_busy", busy, 16'h0200);
      quiet();
      rsv_en = 1'b1;
      rsv_sel = 4'd9;
      wr(0, 4'd9, 32'h99);
      tick();
      check("setwins_busy", busy, 16'h0200);
      check("setwins_ready", rd_ready[1], 1'b1);
      check("setwins_data", rdat(1), 32'h99);
      quiet();
      tick();
      check("still_busy_ready", rd_ready[1], 1'b0);
      wr(1, 4'd9, 32'h9A);
      tick();
      check("p1_clr9_busy", busy, 0);
      quiet();
      rsv_en = 1'b1;
      rsv_sel = 4'd0;
      tick();
      check("rsv0_ignored", busy, 0);
      quiet();

      // Reset mid-operation
      rsv_en = 1'b1;
      rsv_sel = 4'd2;
      tick();
      rsv_sel = 4'd6;
      rsel(0, 4'd2);
      tick();
      check("pre_rst_busy", busy, 16'h0044);
      check("pre_rst_ready0", rd_ready[0], 1'b0);
      quiet();
      rst = 1'b1;
      wr(0, 4'd11, 32'hCC);
      rsv_en = 1'b1;
      rsv_sel = 4'd3;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_ready", rd_ready, 3'b111);
      check("midrst_rd0", rdat(0), 0);
      rst = 1'b0;
      quiet();
      rsel(0, 4'd11);
      rsel(1, 4'd5);
      rsel(2, 4'd3);
      tick();
      check("midrst_r11", rdat(0), 0);
      check("midrst_r5", rdat(1), 0);
      check("midrst_r3", rdat(2), 0);
      check("midrst_ready_after", rd_ready, 3'b111);
      check("midrst_busy_after", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
